// File: rtl/raisin64_mem_pkg.sv
// ---------------------------------------------------------------------------
// raisin64_mem_pkg : shared encodings for the memory port arbiter slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package raisin64_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_select.sv
// ---------------------------------------------------------------------------
// mem_arb_select : fetch/data grant choice, fixed priority or round-robin
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arb_select
  import raisin64_mem_pkg::*;
#(
  parameter int RR_MODE = RR_FIXED
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req_fetch,
  input  logic   i_req_data,
  input  logic   i_grant_en,
  output owner_t o_owner
);

  owner_t r_last;
  owner_t w_owner;

  always_comb begin
    w_owner = OWN_FETCH;
    if (i_req_fetch && i_req_data) begin
      w_owner = (RR_MODE == RR_ROUND) ? other_owner(r_last) : OWN_DATA;
    end else if (i_req_data) begin
      w_owner = OWN_DATA;
    end
  end

  // Resetting to fetch makes the first round-robin contention go to data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= OWN_FETCH;
    end else if (i_grant_en) begin
      r_last <= w_owner;
    end
  end

  assign o_owner = w_owner;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one memory port between fetch and data requesters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import raisin64_mem_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int RR_MODE = RR_FIXED,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_addr_valid,
  output logic [DATA_W-1:0] imem_data,
  output logic              imem_data_valid,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_din,
  input  logic              dmem_rstrobe,
  input  logic              dmem_wstrobe,
  output logic [DATA_W-1:0] dmem_dout,
  output logic              dmem_cycle_complete,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  output logic              mem_addr_valid,
  output logic              mem_dout_write,
  input  logic              mem_din_ready,
  output logic              bus_err
);

  state_t            r_state;
  state_t            w_next;
  owner_t            r_owner;
  owner_t            w_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_imem_data;
  logic [DATA_W-1:0] r_dmem_data;
  logic              r_write;
  logic              r_err;
  logic [31:0]       r_wd_cnt;

  logic w_req_fetch;
  logic w_req_data;
  logic w_start;
  logic w_done;
  logic w_timeout;

  assign w_req_fetch = imem_addr_valid;
  assign w_req_data  = dmem_rstrobe | dmem_wstrobe;
  assign w_start     = (r_state == ST_IDLE) && (w_req_fetch || w_req_data);
  assign w_done      = (r_state == ST_BUSY) && mem_din_ready;
  // The counter holds k-1 in the k-th BUSY cycle, so TIMEOUT-1 marks the last allowed cycle.
  assign w_timeout   = (r_state == ST_BUSY) && !mem_din_ready && (TIMEOUT != 0) &&
                       (r_wd_cnt == 32'(TIMEOUT - 1));

  mem_arb_select #(
    .RR_MODE (RR_MODE)
  ) u_select (
    .clk         (clk),
    .rst         (rst),
    .i_req_fetch (w_req_fetch),
    .i_req_data  (w_req_data),
    .i_grant_en  (w_start),
    .o_owner     (w_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_BUSY;
      ST_BUSY: if (w_done || w_timeout) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_valid      = (r_state == ST_BUSY);
    mem_dout_write      = (r_state == ST_BUSY) && r_write;
    imem_data_valid     = (r_state == ST_RESP) && (r_owner == OWN_FETCH);
    dmem_cycle_complete = (r_state == ST_RESP) && (r_owner == OWN_DATA);
    bus_err             = (r_state == ST_RESP) && r_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWN_FETCH;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_wd_cnt    <= '0;
      r_imem_data <= '0;
      r_dmem_data <= '0;
    end else if (w_start) begin
      r_owner  <= w_grant;
      r_addr   <= (w_grant == OWN_DATA) ? dmem_addr : imem_addr;
      r_write  <= (w_grant == OWN_DATA) && dmem_wstrobe;
      r_err    <= 1'b0;
      r_wd_cnt <= '0;
      if (w_grant == OWN_DATA) begin
        r_wdata <= dmem_din;
      end
    end else if (r_state == ST_BUSY) begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
      if (w_done && !r_write) begin
        if (r_owner == OWN_FETCH) begin
          r_imem_data <= mem_din;
        end else begin
          r_dmem_data <= mem_din;
        end
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign imem_data = r_imem_data;
  assign dmem_dout = r_dmem_data;
  assign mem_addr  = r_addr;
  assign mem_dout  = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : vector table + scoreboard bench for mem_port_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] imem_addr, dmem_addr;
  logic          imem_addr_valid, dmem_rstrobe, dmem_wstrobe;
  logic [DW-1:0] dmem_din, mem_din;

  logic [DW-1:0] a_imem_data, a_dmem_dout, a_mem_dout;
  logic [AW-1:0] a_mem_addr;
  logic          a_imem_dv, a_dmem_cc, a_valid, a_write, a_berr;
  logic          a_ready = 1'b0;
  logic [DW-1:0] b_imem_data, b_dmem_dout, b_mem_dout;
  logic [AW-1:0] b_mem_addr;
  logic          b_imem_dv, b_dmem_cc, b_valid, b_write, b_berr;
  logic          b_ready = 1'b0;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RR_MODE(0), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
    .imem_data(a_imem_data), .imem_data_valid(a_imem_dv),
    .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_rstrobe(dmem_rstrobe), .dmem_wstrobe(dmem_wstrobe),
    .dmem_dout(a_dmem_dout), .dmem_cycle_complete(a_dmem_cc),
    .mem_addr(a_mem_addr), .mem_dout(a_mem_dout), .mem_din(mem_din),
    .mem_addr_valid(a_valid), .mem_dout_write(a_write),
    .mem_din_ready(a_ready), .bus_err(a_berr)
  );

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RR_MODE(1), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
    .imem_data(b_imem_data), .imem_data_valid(b_imem_dv),
    .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_rstrobe(dmem_rstrobe), .dmem_wstrobe(dmem_wstrobe),
    .dmem_dout(b_dmem_dout), .dmem_cycle_complete(b_dmem_cc),
    .mem_addr(b_mem_addr), .mem_dout(b_mem_dout), .mem_din(mem_din),
    .mem_addr_valid(b_valid), .mem_dout_write(b_write),
    .mem_din_ready(b_ready), .bus_err(b_berr)
  );

  typedef struct {
    bit            port;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
    logic [DW-1:0] exp_data;
    bit            exp_err;
  } vec_t;

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    bit            err;
    int            busy;
    logic [AW-1:0] addr;
    bit            wr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   sb_en = 1'b0;
  bit   gq_en = 1'b0;
  bit   ga[$];
  bit   gb[$];
  logic a_pv = 1'b0, b_pv = 1'b0;
  int   busy_n = 0;
  int   lat_a = 1;
  int   a_bc = 0, b_bc = 0;
  int   chk = 0, errs = 0;
  vec_t vecs[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    chk++;
    errs++;
    $display("FAIL %s: got no matching event, expected one", nm);
  endtask

  // Memory responders: ready on the lat-th BUSY cycle (A) or the first (B).
  always @(negedge clk) begin
    if (a_valid) begin
      a_bc = a_bc + 1;
      a_ready = (a_bc == lat_a);
    end else begin
      a_bc = 0;
      a_ready = 1'b0;
    end
    if (b_valid) begin
      b_bc = b_bc + 1;
      b_ready = (b_bc == 1);
    end else begin
      b_bc = 0;
      b_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst || !sb_en) begin
      busy_n = 0;
    end else begin
      if (a_valid) begin
        busy_n++;
        if (sb_q.size() == 0) fail("busy_unexpected");
        else begin
          check("mem_addr", a_mem_addr, sb_q[0].addr);
          check("mem_dout_write", a_write, sb_q[0].wr);
          if (sb_q[0].wr) check("mem_dout", a_mem_dout, sb_q[0].wdata);
        end
      end
      if (a_imem_dv || a_dmem_cc) begin
        if (sb_q.size() == 0) fail("pulse_unexpected");
        else begin
          mon_e = sb_q.pop_front();
          check("pulse_port", {a_dmem_cc, a_imem_dv}, mon_e.port ? 2'b10 : 2'b01);
          check("data_out", mon_e.port ? a_dmem_dout : a_imem_data, mon_e.data);
          check("bus_err", a_berr, mon_e.err);
          check("busy_cycles", busy_n, mon_e.busy);
        end
        busy_n = 0;
      end else begin
        check("bus_err_idle", a_berr, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    if (gq_en) begin
      if (a_valid && !a_pv) ga.push_back(a_mem_addr == 64'h80);
      if (b_valid && !b_pv) gb.push_back(b_mem_addr == 64'h80);
    end
    a_pv = a_valid;
    b_pv = b_valid;
  end

  task automatic wait_done();
    int n = 0;
    while (!(a_imem_dv || a_dmem_cc) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) fail("completion_wait");
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    @(negedge clk);
    lat_a   = v.lat;
    mem_din = v.rdata;
    e.port  = v.port;
    e.data  = v.exp_data;
    e.err   = v.exp_err;
    e.busy  = (v.lat < TO) ? v.lat : TO;
    e.addr  = v.addr;
    e.wr    = v.wr;
    e.wdata = v.wdata;
    sb_q.push_back(e);
    if (v.port) begin
      dmem_addr    = v.addr;
      dmem_din     = v.wdata;
      dmem_rstrobe = v.rd;
      dmem_wstrobe = v.wr;
    end else begin
      imem_addr       = v.addr;
      imem_addr_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check("grant_latency", a_valid, 1'b1);
    wait_done();
    imem_addr_valid = 1'b0;
    dmem_rstrobe    = 1'b0;
    dmem_wstrobe    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    exp_t e;
    int n;
    vecs[0] = '{0, 0, 0, 64'h40,  64'h0,        64'h1122334455667788, 1,    64'h1122334455667788, 0};
    vecs[1] = '{1, 0, 1, 64'h80,  64'hDEADBEEF, 64'hFFFF0000FFFF0000, 3,    64'h0,                0};
    vecs[2] = '{1, 1, 0, 64'h100, 64'h0,        64'hCAFEF00D12345678, 2,    64'hCAFEF00D12345678, 0};
    vecs[3] = '{1, 1, 0, 64'h108, 64'h0,        64'h1111,             1000, 64'hCAFEF00D12345678, 1};
    vecs[4] = '{1, 1, 0, 64'h110, 64'h0,        64'h0123456789ABCDEF, 4,    64'h0123456789ABCDEF, 0};
    vecs[5] = '{0, 0, 0, 64'h44,  64'h0,        64'h55AA55AA00FF00FF, 4,    64'h55AA55AA00FF00FF, 0};
    vecs[6] = '{0, 0, 0, 64'h48,  64'h0,        64'h9999,             1000, 64'h55AA55AA00FF00FF, 1};
    vecs[7] = '{1, 1, 1, 64'h118, 64'h1234,     64'h7777,             2,    64'h0123456789ABCDEF, 0};

    rst = 1'b1;
    imem_addr = '0; dmem_addr = '0; dmem_din = '0; mem_din = '0;
    imem_addr_valid = 1'b0; dmem_rstrobe = 1'b0; dmem_wstrobe = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", a_valid, 1'b0);
    check("rst_write", a_write, 1'b0);
    check("rst_pulses", {a_imem_dv, a_dmem_cc}, 2'b00);
    check("rst_bus_err", a_berr, 1'b0);
    check("rst_imem_data", a_imem_data, 64'h0);
    check("rst_dmem_dout", a_dmem_dout, 64'h0);
    check("rst_mem_addr", a_mem_addr, 64'h0);
    check("rst_mem_dout", a_mem_dout, 64'h0);
    rst   = 1'b0;
    sb_en = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of a BUSY load, then re-request while still held.
    @(negedge clk);
    sb_en = 1'b0;
    lat_a = 1000;
    dmem_addr = 64'h200;
    dmem_rstrobe = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_pre_valid", a_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_valid", a_valid, 1'b0);
    check("midrst_pulses", {a_imem_dv, a_dmem_cc}, 2'b00);
    check("midrst_bus_err", a_berr, 1'b0);
    check("midrst_dmem_dout", a_dmem_dout, 64'h0);
    check("midrst_imem_data", a_imem_data, 64'h0);
    @(posedge clk);
    #1;
    check("midrst_no_pulse", {a_imem_dv, a_dmem_cc}, 2'b00);
    @(negedge clk);
    lat_a   = 1;
    mem_din = 64'h0000_0077_0000_0077;
    e = '{1, 64'h0000_0077_0000_0077, 0, 1, 64'h200, 0, 64'h0};
    sb_q.push_back(e);
    sb_en = 1'b1;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_regrant", a_valid, 1'b1);
    wait_done();
    dmem_rstrobe = 1'b0;
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    // Contention with both requesters held high continuously.
    sb_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_addr = 64'h40;
    dmem_addr = 64'h80;
    imem_addr_valid = 1'b1;
    dmem_rstrobe = 1'b1;
    lat_a = 1;
    gq_en = 1'b1;
    n = 0;
    while ((ga.size() < 4 || gb.size() < 4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    gq_en = 1'b0;
    imem_addr_valid = 1'b0;
    dmem_rstrobe = 1'b0;
    if (ga.size() < 4) fail("grants_fixed");
    if (gb.size() < 4) fail("grants_rr");
    for (int i = 0; i < 4; i++) begin
      if (i < ga.size()) check("grant_fixed_is_data", ga[i], 1'b1);
      if (i < gb.size()) check("grant_rr_alternates", gb[i], (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule

`default_nettype wire
